clk_rate_meter: RTL
===================

# clk_rate_meter

Single-clock rate meter that checks the clocks produced by the clocking block. It samples an asynchronous probe signal in the IFCLK domain, counts its rising edges over a fixed gate window of IFCLK cycles, and publishes the count with a one-cycle strobe and a range verdict. The probe is normally a divided toggle of a generated clock (WORD_GEN_CLK, PKT_COMM_CLK, CORE_CLK or CMP_CLK). It sits beside the clocking block, and host logic reads its result registers.

## Interface
- GATE_CYCLES, default 48000: gate window length in IFCLK cycles (1 ms at 48 MHz); must be ≥ 2.
- GATE_WIDTH, default 16: width of the gate counter; 2^GATE_WIDTH must be ≥ GATE_CYCLES.
- COUNT_WIDTH, default 16: width of the edge counter and of COUNT.
- MIN_COUNT, default 0: lowest in-range count, inclusive.
- MAX_COUNT, default 2^COUNT_WIDTH−1: highest in-range count, inclusive.

Ports:
- IFCLK  in  1  sole clock, 48 MHz.
- RESET_N  in  1  reset, asynchronous and active-low.
- ENABLE  in  1  measurement enable, synchronous to IFCLK.
- SIG_IN  in  1  asynchronous probe; its frequency must be < IFCLK/2.
- COUNT  out  COUNT_WIDTH  edge count of the last completed window.
- VALID  out  1  one-cycle strobe when COUNT is updated.
- FREQ_OK  out  1  MIN_COUNT ≤ COUNT ≤ MAX_COUNT for the last completed window.
- SATURATED  out  1  the edge counter hit all-ones in the last completed window.
- BUSY  out  1  state is not IDLE.

## Operation
- **Synchronizer:** 2-FF synchronizer s1→s2, plus a history flop s3. Edge = s2 & ~s3.
- **State machine:**
  - IDLE: counters held at 0. Go to WARMUP when ENABLE=1.
  - WARMUP: runs exactly 4 cycles; edges are ignored so that reset-value transitions are never counted. Then go to MEASURE.
  - MEASURE: each cycle the gate counter increments and the edge counter adds 1 when edge=1. At gate counter = GATE_CYCLES−1 (the terminal cycle):
    - latch COUNT = edge counter + edge, saturating at 2^COUNT_WIDTH−1;
    - update FREQ_OK and SATURATED from that same value;
    - clear the gate and edge counters;
    - the next window starts on the following cycle, with no gap.
  - ENABLE=0 in any state returns to IDLE on the next cycle. A partial window is discarded: no VALID, and COUNT/FREQ_OK/SATURATED keep their last values.
- **Saturation:** the edge counter never wraps; it holds at all-ones. SATURATED=1 when the latched value is all-ones.
- **Boundary rules:**
  - An edge detected in the terminal cycle belongs to the closing window.
  - An edge in the first MEASURE cycle belongs to the new window.
  - FREQ_OK and SATURATED are recomputed at every window close and are never sticky.

## Timing
- Reset values: COUNT=0, VALID=0, FREQ_OK=0, SATURATED=0, BUSY=0. State is IDLE; all counters and synchronizer flops are 0.
- Asserting RESET_N low clears all outputs immediately (asynchronous), including in the middle of a window. After release, the block waits for ENABLE.
- Latency from a SIG_IN rising edge to the edge pulse is 2–3 IFCLK cycles, depending on setup to the first flop.
- ENABLE rises in cycle 0: BUSY=1 from cycle 1. WARMUP covers cycles 1–4, MEASURE starts in cycle 5, and the first VALID arrives in cycle 5+GATE_CYCLES.
- VALID is registered: it is high for the one cycle after the terminal cycle, and COUNT/FREQ_OK/SATURATED change in that same cycle.
- While ENABLE stays 1, VALID repeats every GATE_CYCLES cycles exactly.
- No backpressure: a consumer that misses VALID reads COUNT, which stays stable until the next VALID.

## Test plan
1. **Nominal rate:** GATE_CYCLES=1000, SIG_IN toggling every 2 IFCLK cycles (IFCLK/4), MIN_COUNT=240, MAX_COUNT=260 → COUNT=250, FREQ_OK=1, SATURATED=0. VALID is first seen 1005 cycles after ENABLE rises, then every 1000 cycles.
2. **Dead probe:** SIG_IN held at 1 through reset and enable, MIN_COUNT=1 → COUNT=0, FREQ_OK=0 on every VALID. No spurious edge is counted during WARMUP.
3. **Saturation:** COUNT_WIDTH=4, GATE_CYCLES=100, SIG_IN at IFCLK/4 → COUNT=15, SATURATED=1. With default MAX_COUNT=15, FREQ_OK=1.
4. **Enable dropped mid-window:** ENABLE=0 at cycle 500 of window 2 → BUSY=0 next cycle, no VALID, and COUNT stays at the window-1 value. Re-enable → next VALID exactly 5+GATE_CYCLES cycles later.
5. **Reset mid-window:** RESET_N low at cycle 300 of a window → all outputs 0 in the same cycle. After release, ENABLE=1 → behaviour matches scenario 1 from cycle 0.
6. **Window boundary:** inject single isolated SIG_IN pulses so that edges are detected in the terminal cycle and in the first cycle of the next window → each edge is counted exactly once, in its own window (window N count +1, window N+1 count +1).

Source files
------------

// File: rtl/clk_rate_meter.sv
// ----------------------------------------------------------------------------
// clk_rate_meter
//
// Rate meter for the clocking block outputs. An asynchronous probe (normally
// a divided toggle of a generated clock) is synchronised into ifclk. Its rising
// edges are counted over a fixed gate window of GATE_CYCLES ifclk cycles. Each
// completed window publishes its count with a one-cycle strobe and a range
// verdict. Windows run back to back while enable stays high.
//
// Ports
//   ifclk      in   sole clock
//   reset_n    in   asynchronous active-low reset
//   enable     in   measurement enable, synchronous to ifclk
//   sig_in     in   asynchronous probe, frequency below ifclk/2
//   count      out  edge count of the last completed window (saturating)
//   valid      out  one-cycle strobe, high in the cycle count is updated
//   freq_ok    out  MIN_COUNT <= count <= MAX_COUNT for the last window
//   saturated  out  edge counter reached all-ones in the last window
//   busy       out  state is not IDLE
//
// State table
//   state   | meaning
//   IDLE    | counters held at 0, waiting for enable
//   WARMUP  | 4 cycles, edges ignored so synchroniser start-up is never counted
//   MEASURE | gate window running, edges accumulated
// ----------------------------------------------------------------------------
module clk_rate_meter #(
  parameter int GATE_CYCLES = 48000,
  parameter int GATE_WIDTH  = 16,
  parameter int COUNT_WIDTH = 16,
  parameter int MIN_COUNT   = 0,
  parameter int MAX_COUNT   = 2**COUNT_WIDTH - 1
) (
  input  logic                   ifclk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   sig_in,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   valid,
  output logic                   freq_ok,
  output logic                   saturated,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARMUP  = 2'd1,
    MEASURE = 2'd2
  } state_t;

  // The gate counter counts down the cycles left in the window; zero marks
  // the terminal cycle.
  localparam logic [GATE_WIDTH-1:0]  GATE_LAST = GATE_WIDTH'(GATE_CYCLES - 1);
  localparam logic [1:0]             WARM_LAST = 2'd3;
  localparam logic [COUNT_WIDTH-1:0] EDGE_MAX  = '1;
  localparam logic [COUNT_WIDTH-1:0] MIN_C     = COUNT_WIDTH'(MIN_COUNT);
  localparam logic [COUNT_WIDTH-1:0] MAX_C     = COUNT_WIDTH'(MAX_COUNT);

  state_t                 state;
  logic                   s1;
  logic                   s2;
  logic                   s3;
  logic                   edge_det;
  logic [1:0]             warm_cnt;
  logic [GATE_WIDTH-1:0]  gate_cnt;
  logic [COUNT_WIDTH-1:0] edge_cnt;
  logic [COUNT_WIDTH-1:0] edge_next;
  logic                   above_min;
  logic                   below_max;

  // Synchroniser plus history flop; runs regardless of state.
  always_ff @(posedge ifclk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_det = s2 & ~s3;

  // Saturating accumulate. In the terminal cycle this is also the value that
  // closes the window, so an edge there lands in the closing window.
  assign edge_next = (edge_det && (edge_cnt != EDGE_MAX)) ?
                     edge_cnt + COUNT_WIDTH'(1) : edge_cnt;

  // Bounds that cover the whole count range are tied off rather than compared,
  // avoiding always-true unsigned comparisons.
  generate
    if (MIN_COUNT <= 0) begin : g_min_open
      assign above_min = 1'b1;
    end else begin : g_min_cmp
      assign above_min = (edge_next >= MIN_C);
    end
    if (MAX_COUNT >= (2**COUNT_WIDTH - 1)) begin : g_max_open
      assign below_max = 1'b1;
    end else begin : g_max_cmp
      assign below_max = (edge_next <= MAX_C);
    end
  endgenerate

  always_ff @(posedge ifclk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      warm_cnt  <= '0;
      gate_cnt  <= '0;
      edge_cnt  <= '0;
      count     <= '0;
      valid     <= 1'b0;
      freq_ok   <= 1'b0;
      saturated <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!enable) begin
        // Any partial window is dropped; published results are kept.
        state    <= IDLE;
        busy     <= 1'b0;
        warm_cnt <= '0;
        gate_cnt <= '0;
        edge_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            state    <= WARMUP;
            busy     <= 1'b1;
            warm_cnt <= WARM_LAST;
          end
          WARMUP: begin
            if (warm_cnt == 2'd0) begin
              state    <= MEASURE;
              gate_cnt <= GATE_LAST;
              edge_cnt <= '0;
            end else begin
              warm_cnt <= warm_cnt - 2'd1;
            end
          end
          MEASURE: begin
            if (gate_cnt == '0) begin
              valid     <= 1'b1;
              count     <= edge_next;
              freq_ok   <= above_min & below_max;
              saturated <= (edge_next == EDGE_MAX);
              gate_cnt  <= GATE_LAST;
              edge_cnt  <= '0;
            end else begin
              gate_cnt <= gate_cnt - GATE_WIDTH'(1);
              edge_cnt <= edge_next;
            end
          end
          default: begin
            state    <= IDLE;
            busy     <= 1'b0;
            warm_cnt <= '0;
            gate_cnt <= '0;
            edge_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule
